// File: rtl/mac_job_ctrl.sv
// Job-level sequencer for a packed-lane MAC datapath: accepts a job, streams its
// operand beats to the datapath, waits out the pipeline, then reports completion.
module mac_job_ctrl #(
  parameter int MAC_CONF_WIDTH = 4,
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int CNT_WIDTH      = 8,
  parameter int PIPE_DEPTH     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         job_valid,
  output logic                         job_ready,
  input  logic [MAC_CONF_WIDTH-1:0]    job_cfg,
  input  logic [CNT_WIDTH-1:0]         job_len,
  input  logic                         op_valid,
  output logic                         op_ready,
  input  logic [8*MAC_MIN_WIDTH-1:0]   op_data,
  input  logic                         abort,
  output logic [MAC_CONF_WIDTH-1:0]    dp_cfg,
  output logic                         dp_en,
  output logic [8*MAC_MIN_WIDTH-1:0]   dp_data,
  output logic                         dp_clear,
  output logic                         dp_last,
  output logic [CNT_WIDTH-1:0]         beat_cnt,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic                         aborted
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int                    DW         = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [DW-1:0]         DRAIN_LOAD = DW'(PIPE_DEPTH - 1);
  localparam logic [DW-1:0]         DRAIN_ONE  = DW'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = CNT_WIDTH'(1);

  state_t               state;
  logic [CNT_WIDTH-1:0] rem_cnt;
  logic [DW-1:0]        drain_cnt;

  assign job_ready = (state == IDLE);
  assign op_ready  = (state == RUN) & ~abort;
  assign busy      = (state != IDLE);

  // NOTE: every register here uses <= so all next-state values derive from the
  // pre-edge state; dp_data is a plain register and is reset like the rest.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rem_cnt   <= '0;
      drain_cnt <= '0;
      dp_cfg    <= '0;
      dp_en     <= 1'b0;
      dp_data   <= '0;
      dp_clear  <= 1'b0;
      dp_last   <= 1'b0;
      beat_cnt  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      dp_en    <= 1'b0;
      dp_clear <= 1'b0;
      dp_last  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      aborted  <= 1'b0;
      case (state)
        IDLE: begin
          if (job_valid) begin
            // Lane mode 2'b11 has no datapath meaning; reject without touching dp_cfg.
            if (job_cfg[1:0] == 2'b11) begin
              err <= 1'b1;
            end else begin
              dp_cfg    <= job_cfg;
              rem_cnt   <= job_len;
              beat_cnt  <= '0;
              drain_cnt <= DRAIN_LOAD;
              state     <= (job_len == '0) ? DRAIN : RUN;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state   <= IDLE;
            aborted <= 1'b1;
          end else if (op_valid) begin
            dp_en    <= 1'b1;
            dp_data  <= op_data;
            dp_clear <= (beat_cnt == '0);
            dp_last  <= (rem_cnt == CNT_ONE);
            beat_cnt <= beat_cnt + CNT_ONE;
            rem_cnt  <= rem_cnt - CNT_ONE;
            if (rem_cnt == CNT_ONE) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (abort) begin
            state   <= IDLE;
            aborted <= 1'b1;
          end else if (drain_cnt == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DRAIN_ONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_job_ctrl.sv
// Directed bench for mac_job_ctrl: per-cycle output histories compared against
// hand-derived bit patterns for each job scenario.
module tb_mac_job_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid, job_ready;
  logic [3:0]  job_cfg;
  logic [7:0]  job_len;
  logic        op_valid, op_ready;
  logic [63:0] op_data;
  logic        abort;
  logic [3:0]  dp_cfg;
  logic        dp_en, dp_clear, dp_last;
  logic [63:0] dp_data;
  logic [7:0]  beat_cnt;
  logic        busy, done, err, aborted;

  int tests = 0;
  int fails = 0;

  logic [31:0] en_h, clr_h, last_h, done_h, err_h, abt_h, busy_h;
  logic [63:0] dat_h [0:31];

  mac_job_ctrl dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_cfg(job_cfg), .job_len(job_len),
    .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data), .abort(abort),
    .dp_cfg(dp_cfg), .dp_en(dp_en), .dp_data(dp_data), .dp_clear(dp_clear),
    .dp_last(dp_last), .beat_cnt(beat_cnt), .busy(busy), .done(done),
    .err(err), .aborted(aborted)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] beat_data(input int c);
    return {8'(c), 56'h11223344556677};
  endfunction

  // Cycle 0 is the cycle the job is offered; history bit k holds the output during cycle k.
  task automatic run_job(input logic [3:0] cfg, input logic [7:0] len,
                         input logic [31:0] jvm, input logic [31:0] vm,
                         input logic [31:0] am, input int ncyc);
    en_h = '0; clr_h = '0; last_h = '0; done_h = '0; err_h = '0; abt_h = '0; busy_h = '0;
    job_cfg = cfg; job_len = len;
    job_valid = jvm[0]; op_valid = vm[0]; abort = am[0]; op_data = beat_data(0);
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk); #1;
      en_h[k] = dp_en; clr_h[k] = dp_clear; last_h[k] = dp_last; done_h[k] = done;
      err_h[k] = err; abt_h[k] = aborted; busy_h[k] = busy; dat_h[k] = dp_data;
      job_valid = jvm[k]; op_valid = vm[k]; abort = am[k]; op_data = beat_data(k);
    end
    job_valid = 1'b0; op_valid = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; job_valid = 1'b1; job_cfg = 4'b0001; job_len = 8'd1;
    op_valid = 1'b1; op_data = 64'hFFFF; abort = 1'b0;
    #3;
    tests++; if ({dp_cfg, dp_en, dp_data, dp_clear, dp_last, beat_cnt, done, err, aborted} !== '0) begin
      fails++; $display("FAIL reset_regs got nonzero register outputs cfg=%h en=%b data=%h cnt=%h", dp_cfg, dp_en, dp_data, beat_cnt); end
    tests++; if ({busy, op_ready, job_ready} !== 3'b001) begin
      fails++; $display("FAIL reset_comb got %b exp %b", {busy, op_ready, job_ready}, 3'b001); end
    @(posedge clk); #1;
    tests++; if ({busy, err, dp_cfg} !== 6'b0) begin
      fails++; $display("FAIL reset_no_handshake got %b exp %b", {busy, err, dp_cfg}, 6'b0); end
    job_valid = 1'b0; op_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    run_job(4'b1010, 8'd3, 32'h1, 32'hFFFF_FFFE, 32'h0, 8);
    tests++; if (en_h !== 32'h1C) begin fails++; $display("FAIL nom_en got %h exp %h", en_h, 32'h1C); end
    tests++; if (clr_h !== 32'h04) begin fails++; $display("FAIL nom_clear got %h exp %h", clr_h, 32'h04); end
    tests++; if (last_h !== 32'h10) begin fails++; $display("FAIL nom_last got %h exp %h", last_h, 32'h10); end
    tests++; if (done_h !== 32'h40) begin fails++; $display("FAIL nom_done got %h exp %h", done_h, 32'h40); end
    tests++; if (dat_h[2] !== beat_data(1)) begin fails++; $display("FAIL nom_data0 got %h exp %h", dat_h[2], beat_data(1)); end
    tests++; if (dat_h[4] !== beat_data(3)) begin fails++; $display("FAIL nom_data2 got %h exp %h", dat_h[4], beat_data(3)); end
    tests++; if (dat_h[6] !== beat_data(3)) begin fails++; $display("FAIL nom_data_hold got %h exp %h", dat_h[6], beat_data(3)); end
    tests++; if (dp_cfg !== 4'b1010) begin fails++; $display("FAIL nom_cfg got %h exp %h", dp_cfg, 4'b1010); end
    tests++; if (beat_cnt !== 8'd3) begin fails++; $display("FAIL nom_beat_cnt got %0d exp %0d", beat_cnt, 3); end
  endtask

  task automatic test_illegal_cfg();
    run_job(4'b0111, 8'd5, 32'h1, 32'hFFFF_FFFF, 32'h0, 3);
    tests++; if (err_h !== 32'h2) begin fails++; $display("FAIL ill_err got %h exp %h", err_h, 32'h2); end
    tests++; if (busy_h !== 32'h0) begin fails++; $display("FAIL ill_busy got %h exp %h", busy_h, 32'h0); end
    tests++; if (dp_cfg !== 4'b1010) begin fails++; $display("FAIL ill_cfg got %h exp %h", dp_cfg, 4'b1010); end
  endtask

  task automatic test_stall();
    run_job(4'b0001, 8'd2, 32'h1, 32'h22, 32'h0, 10);
    tests++; if (en_h !== 32'h44) begin fails++; $display("FAIL stall_en got %h exp %h", en_h, 32'h44); end
    tests++; if (last_h !== 32'h40) begin fails++; $display("FAIL stall_last got %h exp %h", last_h, 32'h40); end
    tests++; if (done_h !== 32'h100) begin fails++; $display("FAIL stall_done got %h exp %h", done_h, 32'h100); end
    tests++; if (dat_h[6] !== beat_data(5)) begin fails++; $display("FAIL stall_data got %h exp %h", dat_h[6], beat_data(5)); end
  endtask

  task automatic test_len_bounds();
    run_job(4'b0100, 8'd1, 32'h1, 32'hFFFF_FFFE, 32'h0, 6);
    tests++; if ({en_h, clr_h, last_h} !== {32'h4, 32'h4, 32'h4}) begin
      fails++; $display("FAIL len1_flags got %h/%h/%h exp 4/4/4", en_h, clr_h, last_h); end
    tests++; if (done_h !== 32'h10) begin fails++; $display("FAIL len1_done got %h exp %h", done_h, 32'h10); end
    run_job(4'b1000, 8'd0, 32'h1, 32'hFFFF_FFFF, 32'h0, 5);
    tests++; if (en_h !== 32'h0) begin fails++; $display("FAIL len0_en got %h exp %h", en_h, 32'h0); end
    tests++; if (done_h !== 32'h8) begin fails++; $display("FAIL len0_done got %h exp %h", done_h, 32'h8); end
    tests++; if (beat_cnt !== 8'd0) begin fails++; $display("FAIL len0_beat_cnt got %0d exp %0d", beat_cnt, 0); end
  endtask

  task automatic test_abort();
    run_job(4'b0110, 8'd3, 32'h1, 32'hFFFF_FFFF, 32'h8, 8);
    tests++; if (en_h !== 32'h0C) begin fails++; $display("FAIL abt_en got %h exp %h", en_h, 32'h0C); end
    tests++; if (last_h !== 32'h0) begin fails++; $display("FAIL abt_last got %h exp %h", last_h, 32'h0); end
    tests++; if (abt_h !== 32'h10) begin fails++; $display("FAIL abt_pulse got %h exp %h", abt_h, 32'h10); end
    tests++; if (done_h !== 32'h0) begin fails++; $display("FAIL abt_done got %h exp %h", done_h, 32'h0); end
    tests++; if (busy_h !== 32'h0E) begin fails++; $display("FAIL abt_busy got %h exp %h", busy_h, 32'h0E); end
    tests++; if ({dp_cfg, beat_cnt} !== {4'b0110, 8'd2}) begin
      fails++; $display("FAIL abt_cfg_cnt got %h exp %h", {dp_cfg, beat_cnt}, {4'b0110, 8'd2}); end
  endtask

  task automatic test_back_to_back();
    // job_valid held through DONE (with an ignored abort there) -> second job starts a cycle later.
    run_job(4'b0010, 8'd0, 32'hFF, 32'h0, 32'h8, 9);
    tests++; if (done_h !== 32'h88) begin fails++; $display("FAIL b2b_done got %h exp %h", done_h, 32'h88); end
    tests++; if (busy_h !== 32'hEE) begin fails++; $display("FAIL b2b_busy got %h exp %h", busy_h, 32'hEE); end
    tests++; if (abt_h !== 32'h0) begin fails++; $display("FAIL b2b_aborted got %h exp %h", abt_h, 32'h0); end
  endtask

  task automatic test_reset_mid_job();
    logic saw_done;
    saw_done = 1'b0;
    job_valid = 1'b1; job_cfg = 4'b0001; job_len = 8'd2; op_valid = 1'b1; abort = 1'b0;
    @(posedge clk); #1; job_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++; if ({busy, op_ready} !== 2'b10) begin fails++; $display("FAIL rmid_in_drain got %b exp %b", {busy, op_ready}, 2'b10); end
    #2 rst = 1'b0;
    #1;
    tests++; if ({dp_cfg, dp_en, dp_data, dp_clear, dp_last, beat_cnt, done, err, aborted, busy, op_ready} !== '0) begin
      fails++; $display("FAIL rmid_async_clear got cfg=%h cnt=%h busy=%b", dp_cfg, beat_cnt, busy); end
    job_valid = 1'b1; job_cfg = 4'b0101; job_len = 8'd0; op_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      saw_done = saw_done | done | busy;
    end
    tests++; if (saw_done !== 1'b0) begin fails++; $display("FAIL rmid_no_done got %b exp %b", saw_done, 1'b0); end
    rst = 1'b1;
    @(posedge clk); #1; job_valid = 1'b0;
    tests++; if ({busy, dp_cfg} !== {1'b1, 4'b0101}) begin
      fails++; $display("FAIL rmid_first_edge got %h exp %h", {busy, dp_cfg}, {1'b1, 4'b0101}); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL rmid_new_done got %b exp %b", done, 1'b1); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_illegal_cfg();
    test_stall();
    test_len_bounds();
    test_abort();
    test_back_to_back();
    test_reset_mid_job();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mac_job_ctrl.md
MAC_JOB_CTRL -- requirements
Module: mac_job_ctrl

Interface
REQ-001 SHALL have parameter MAC_CONF_WIDTH, default 4, the cfg word width: bit3 signed, bit2 mac/mul, bits[1:0] single/dual/quad.
REQ-002 SHALL have parameter MAC_MIN_WIDTH, default 8, the width of one operand lane.
REQ-003 SHALL have parameter CNT_WIDTH, default 8, the width of the job length and beat counter.
REQ-004 SHALL have parameter PIPE_DEPTH, default 2, the datapath latency in cycles; legal values are 1 or more.
REQ-005 SHALL have ports, one per line:
- clk  in  1  the only clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- job_valid  in  1  job request.
- job_ready  out  1  job can be accepted; equals (state==IDLE).
- job_cfg  in  MAC_CONF_WIDTH  cfg for the job.
- job_len  in  CNT_WIDTH  number of operand beats in the job.
- op_valid  in  1  operand beat offered.
- op_ready  out  1  beat can be accepted; equals (state==RUN) & ~abort.
- op_data  in  8*MAC_MIN_WIDTH  packed beat {B3,A3,B2,A2,B1,A1,B0,A0}, with A0 in the LSBs.
- abort  in  1  cancels the current job.
- dp_cfg  out  MAC_CONF_WIDTH  registered cfg to the datapath.
- dp_en  out  1  registered datapath enable.
- dp_data  out  8*MAC_MIN_WIDTH  registered operand beat.
- dp_clear  out  1  accumulator clear, qualifies the first beat of a job.
- dp_last  out  1  qualifies the final beat of a job.
- beat_cnt  out  CNT_WIDTH  beats accepted in the current job.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when a job completes.
- err  out  1  one-cycle pulse when a job is rejected.
- aborted  out  1  one-cycle pulse when a job is aborted.

Function
REQ-006 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-007 In IDLE, on job_valid with job_cfg[1:0]==2'b11, the block SHALL pulse err the next cycle, remain in IDLE, and leave dp_cfg unchanged.
REQ-008 In IDLE, on job_valid with a legal cfg, the block SHALL latch job_cfg into dp_cfg, load the remaining count from job_len, clear beat_cnt, and enter RUN (job_len>0) or DRAIN (job_len==0).
REQ-009 In RUN, each beat (op_valid & op_ready) SHALL produce, on the next cycle, dp_en=1 and dp_data=op_data, and SHALL increment beat_cnt and decrement the remaining count.
REQ-010 In every cycle without a beat accepted in the previous cycle, dp_en, dp_clear and dp_last SHALL be 0 and dp_data SHALL hold its last value.
REQ-011 dp_clear SHALL be 1 only with the first beat of a job.
REQ-012 dp_last SHALL be 1 only with the final beat of a job.
REQ-013 For job_len==1, dp_clear and dp_last SHALL both be 1 with the single beat.
REQ-014 On the final beat the block SHALL enter DRAIN.
REQ-015 The block SHALL stay in DRAIN for exactly PIPE_DEPTH cycles, then enter DONE.
REQ-016 DONE SHALL last one cycle, with done=1, and SHALL then return to IDLE.
REQ-017 Latency with no stalls: job accepted at cycle t with job_len=N gives done at cycle t+N+PIPE_DEPTH+1.
REQ-018 When op_valid stalls in RUN, the block SHALL wait indefinitely, with dp_en=0 in the stall cycles.
REQ-019 abort in RUN or DRAIN SHALL move the block to IDLE next cycle and pulse aborted.
REQ-020 Abort behaviour:
- No beat SHALL be accepted in an abort cycle.
- done SHALL NOT pulse for an aborted job.
- dp_cfg SHALL hold its value.
REQ-021 abort in IDLE or DONE SHALL be ignored, and a DONE cycle SHALL still pulse done.
REQ-022 A job_valid while the block is in DONE SHALL NOT be accepted; a job SHALL be accepted the cycle after DONE at the earliest.
REQ-023 beat_cnt SHALL never wrap, since job_len is at most 2^CNT_WIDTH-1.
REQ-024 dp_cfg SHALL be stable from job accept until the next accepted job.

Reset
REQ-025 While rst==0, the state SHALL be IDLE and all registered outputs SHALL be 0: dp_cfg, dp_en, dp_data, dp_clear, dp_last, beat_cnt, done, err, aborted.
REQ-026 While rst==0, busy SHALL be 0 and op_ready SHALL be 0.
REQ-027 While rst==0, job_ready SHALL read 1, but no handshake SHALL take effect.
REQ-028 Asserting rst mid-job SHALL discard the job with no done pulse.
REQ-029 After rst rises, the block SHALL accept a job on the first clock edge.

Verification
REQ-030 Nominal job: PIPE_DEPTH=2, job accepted at cycle 0 with cfg=4'b1010 and len=3, op_valid held at 1 -> dp_en=1 at cycles 2-4, dp_clear at cycle 2, dp_last at cycle 4, done at cycle 6, dp_cfg=4'b1010, beat_cnt=3.
REQ-031 Stalls: len=2 with op_valid low for 3 cycles between the beats -> exactly 2 dp_en pulses, done at 2+3+2+1 = 8 cycles after accept.
REQ-032 Length boundaries:
- len=0 -> no dp_en, done at cycle 3.
- len=1 -> dp_clear=dp_last=1 on the same beat.
REQ-033 Illegal cfg: job with cfg[1:0]=2'b11 -> err pulses once, busy stays 0, and dp_cfg keeps its previous value.
REQ-034 Abort: abort asserted together with op_valid on the final beat -> the beat is not accepted, dp_last never asserts, aborted pulses, done stays 0, and the block is in IDLE next cycle.
REQ-035 Reset mid-job: rst=0 during DRAIN -> all outputs 0 immediately with no clock needed, no done pulse, and a new job is accepted on the first edge after release.
